// File: rtl/icache_mem_responder_pkg.sv
// Shared types and the line data pattern for the icache downstream memory responder.
// Used by the responder RTL and by any scoreboard that checks refill data.
package icache_mem_responder_pkg;

  localparam int MEM_RSP_TS_W   = 16;
  localparam int MEM_RSP_ADDR_W = 32;
  localparam int MEM_RSP_ID_W   = 4;

  typedef struct packed {
    logic [MEM_RSP_ADDR_W-1:0] line_addr;
    logic [MEM_RSP_ID_W-1:0]   entry_id;
    logic [MEM_RSP_TS_W-1:0]   ts;
  } mem_rsp_entry_t;

  typedef enum logic {
    RSP_IDLE = 1'b0,
    RSP_SEND = 1'b1
  } rsp_state_e;

  // 32-bit word w of a line is the low address word xor'd with the word index.
  function automatic logic [31:0] mem_rsp_word(input logic [MEM_RSP_ADDR_W-1:0] line_addr,
                                               input logic [31:0]                w);
    return line_addr[31:0] ^ w;
  endfunction

endpackage

// File: rtl/icache_mem_rsp_fifo.sv
// In-order request queue for the memory responder: DEPTH entries, show-ahead head,
// registered occupancy count with full/empty flags.
module icache_mem_rsp_fifo
  import icache_mem_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  mem_rsp_entry_t         push_data,
  input  logic                   pop,
  output mem_rsp_entry_t         head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  mem_rsp_entry_t mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/icache_mem_responder.sv
// Downstream memory responder for the icache miss path: queues refill requests and returns
// address-patterned lines as multi-beat bursts after LATENCY cycles. Optional: ICACHE_MEM_RSP_STALL_EN.
module icache_mem_responder
  import icache_mem_responder_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int ENTRY_ID_W = 4,
  parameter int LINE_W     = 512,
  parameter int DATA_W     = 256,
  parameter int DEPTH      = 8,
  parameter int LATENCY    = 20,
  localparam int BEATS     = LINE_W / DATA_W,
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  downstream_txreq_vld,
  output logic                  downstream_txreq_rdy,
  input  logic [ADDR_W-1:0]     downstream_txreq_pld,
  input  logic [ENTRY_ID_W-1:0] downstream_txreq_entry_id,
  output logic                  downstream_rxdat_vld,
  input  logic                  downstream_rxdat_rdy,
  output logic [DATA_W-1:0]     downstream_rxdat_pld,
  output logic [ENTRY_ID_W-1:0] downstream_rxdat_entry_id,
  output logic [BEAT_W-1:0]     downstream_rxdat_beat,
  output logic                  downstream_rxdat_last,
  output logic                  busy
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int WPB   = DATA_W / 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0]       OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [MEM_RSP_TS_W-1:0] LAT       = MEM_RSP_TS_W'(LATENCY);
  localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(BEATS - 1);

  rsp_state_e              state_q;
  rsp_state_e              state_d;
  logic [BEAT_W-1:0]       beat_q;
  logic [BEAT_W-1:0]       beat_d;
  logic [MEM_RSP_TS_W-1:0] now_q;
  logic                    rdy_en_q;
  logic                    push;
  logic                    pop;
  logic                    handshake;
  logic                    head_elig;
  logic [MEM_RSP_TS_W-1:0] head_age;
  mem_rsp_entry_t          push_entry;
  mem_rsp_entry_t          head;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    empty;

  assign push                 = downstream_txreq_vld && downstream_txreq_rdy;
  assign push_entry.line_addr = MEM_RSP_ADDR_W'(downstream_txreq_pld & ~OFF_MASK);
  assign push_entry.entry_id  = MEM_RSP_ID_W'(downstream_txreq_entry_id);
  assign push_entry.ts        = now_q;

  icache_mem_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Age is taken modulo 2^16 so eligibility survives the cycle counter wrapping.
  assign head_age  = now_q - head.ts;
  assign head_elig = !empty && (head_age >= LAT);
  assign handshake = downstream_rxdat_vld && downstream_rxdat_rdy;
  assign pop       = handshake && (beat_q == LAST_BEAT);
  assign busy      = (count != '0);

`ifdef ICACHE_MEM_RSP_STALL_EN
  logic [2:0] acc_cnt_q;
  logic       stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q <= '0;
      stall_q   <= 1'b0;
    end else begin
      stall_q <= push && (acc_cnt_q[1:0] == 2'b11);
      if (push) begin
        acc_cnt_q <= acc_cnt_q + 3'd1;
      end
    end
  end

  assign downstream_txreq_rdy = rdy_en_q && !full && !stall_q;
`else
  assign downstream_txreq_rdy = rdy_en_q && !full;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RSP_IDLE;
      beat_q   <= '0;
      now_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      now_q    <= now_q + 1'b1;
      rdy_en_q <= 1'b1;
    end
  end

  // IDLE offers an aged-in head straight away, so the next line follows the last beat with no bubble.
  always_comb begin
    state_d              = state_q;
    beat_d               = beat_q;
    downstream_rxdat_vld = 1'b0;
    case (state_q)
      RSP_IDLE: downstream_rxdat_vld = head_elig;
      RSP_SEND: downstream_rxdat_vld = 1'b1;
      default:  downstream_rxdat_vld = 1'b0;
    endcase
    if (downstream_rxdat_vld) begin
      state_d = RSP_SEND;
      if (downstream_rxdat_rdy) begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = RSP_IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    downstream_rxdat_pld      = '0;
    downstream_rxdat_entry_id = '0;
    downstream_rxdat_beat     = '0;
    downstream_rxdat_last     = 1'b0;
    if (downstream_rxdat_vld) begin
      downstream_rxdat_entry_id = ENTRY_ID_W'(head.entry_id);
      downstream_rxdat_beat     = beat_q;
      downstream_rxdat_last     = (beat_q == LAST_BEAT);
      for (int i = 0; i < WPB; i++) begin
        downstream_rxdat_pld[i*32 +: 32] = mem_rsp_word(head.line_addr, 32'(int'(beat_q) * WPB + i));
      end
    end
  end

endmodule

// File: doc/icache_mem_responder.md
Name: icache_mem_responder

Overview:
Synthesizable downstream memory responder for the icache miss path. Sinks refill requests issued on the icache downstream_txreq channel and returns line data on the downstream_rxdat channel after a programmable latency, in request order, as multi-beat bursts. Sits between icache_top and the system bench (or an FPGA shell) in place of the behavioural DDR model. Line contents follow a deterministic address-derived pattern so the scoreboard checks data without a backing store.

Parameters:
ADDR_W, 32, request address width
ENTRY_ID_W, 4, MSHR entry id width, echoed back with the data
LINE_W, 512, cache line width in bits
DATA_W, 256, rxdat beat width; BEATS = LINE_W/DATA_W, must be an integer >= 1
DEPTH, 8, outstanding request capacity (power of 2)
LATENCY, 20, minimum cycles from request accept to first data beat valid (1..65535)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
downstream_txreq_vld  in  1  refill request valid
downstream_txreq_rdy  out  1  request accepted when vld & rdy
downstream_txreq_pld  in  ADDR_W  request byte address
downstream_txreq_entry_id  in  ENTRY_ID_W  requesting MSHR entry
downstream_rxdat_vld  out  1  data beat valid
downstream_rxdat_rdy  in  1  icache accepts beat
downstream_rxdat_pld  out  DATA_W  beat data
downstream_rxdat_entry_id  out  ENTRY_ID_W  echoed entry id
downstream_rxdat_beat  out  clog2(BEATS) max 1  beat index, 0 first
downstream_rxdat_last  out  1  final beat of line
busy  out  1  any request outstanding

Behaviour:
- Reset: txreq_rdy=0 while rst_n low, then 1; rxdat_vld=0, pld/entry_id/beat/last=0, busy=0; queue and cycle counter cleared. Mid-burst reset discards all queued and in-flight requests; no partial beat reappears.
- 16-bit free-running cycle counter `now`. Each accepted request pushes {line_addr = pld with low clog2(LINE_W/8) bits zeroed, entry_id, ts=now} to an in-order queue.
- txreq_rdy = (count < DEPTH). Depends only on registered count; a same-cycle pop does not free space early.
- Head eligible when (now - ts) mod 2^16 >= LATENCY. rxdat_vld rises on the first cycle eligibility holds. A request accepted in cycle T gives first vld no earlier than cycle T+LATENCY.
- Burst FSM: IDLE -> (head eligible) SEND -> on each vld&rdy beat++; on last beat handshake pop head, then go to SEND again if the next head is already eligible (back-to-back, no bubble), else IDLE.
- While vld=1 and rdy=0, pld/entry_id/beat/last are held stable. vld never drops without a handshake.
- Data pattern: 32-bit word w of the line (w = 0..LINE_W/32-1) = line_addr[31:0] ^ w. Beat b carries words b*DATA_W/32 .. (b+1)*DATA_W/32-1, with the lowest word in the lsbs.
- Simultaneous push and pop: both apply, count unchanged.
- Full: txreq_rdy=0, requests wait. Empty: vld=0.
- busy = (count != 0).

Optional Feature:
ICACHE_MEM_RSP_STALL_EN. When defined, an extra 3-bit accept counter forces txreq_rdy=0 for exactly one cycle after every 4th accepted request, to exercise icache request backpressure. When not defined, txreq_rdy depends only on queue occupancy.

Decomposition:
- toy_pack gains: mem_rsp_entry_t struct {line_addr, entry_id, ts}, MEM_RSP_TS_W=16, and the word-pattern function mem_rsp_word(line_addr, w), shared with the scoreboard.
- Sub-module icache_mem_rsp_fifo: generic DEPTH x mem_rsp_entry_t synchronous FIFO with push/pop/count, full and empty flags.

Test Plan:
- Single request addr=0x0000_1040, id=3, LATENCY=20, rdy=1: first vld exactly 20 cycles after accept; beat0 word0=0x0000_1040, beat1 word8=0x0000_1048, id=3, last on beat1.
- Eight back-to-back requests with rxdat_rdy=0: accepts 8, rdy low on 9th, busy=1. Release rdy: 16 beats in order with no inter-line bubble, then rdy returns.
- rxdat_rdy toggling 1-0-1 mid-burst: pld and beat held during stall, no beat skipped or duplicated.
- Counter wrap: request accepted at now=0xFFF8: data valid at now=0x000C, not earlier.
- rst_n pulsed low during beat1 of a burst with 3 queued: vld=0 immediately, busy=0, no stale beats after release.
- With ICACHE_MEM_RSP_STALL_EN and continuous requests: rdy low exactly one cycle after accepts 4 and 8. Without the macro, no rdy drop while not full.
